// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed data memory responder with programmable wait states
// Optional misaligned-access fault reporting: define MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  // Commit operands: the latched request, or the live request when there are no wait states
  logic          commit;
  logic          c_we;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          misaligned;
  logic          mem_we;

  logic          unused_bits;
  assign unused_bits = ^{req_addr[31:AW+2], c_addr[1:0]};

  assign c_idx = c_addr[AW+1:2];

  always_comb begin
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    misaligned = (c_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    commit     = 1'b0;
    c_we       = we_q;
    c_addr     = addr_q;
    c_wdata    = wdata_q;
    mem_we     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
            c_we    = req_we;
            c_addr  = req_addr[AW+1:0];
            c_wdata = req_wdata;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      err_d = misaligned;
      if (misaligned || c_we) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = mem_q[c_idx];
      end
      mem_we = c_we && !misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset, but a store landing on a reset edge is dropped
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (W=2/D=64 and W=0/D=16)
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        r0_valid, r0_ready, r0_we, r0_resp_valid, r0_resp_ready, r0_resp_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;

  int n_pass;
  int n_total;

  logic [31:0] model  [64];
  logic [31:0] model0 [16];

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
    .req_addr(r0_addr), .req_wdata(r0_wdata),
    .resp_valid(r0_resp_valid), .resp_ready(r0_resp_ready),
    .resp_rdata(r0_rdata), .resp_err(r0_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_misaligned(input logic [31:0] addr);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] addr, input int depth);
    return int'((addr % (depth * 4)) / 4);
  endfunction

  // Reference outcome of one transaction on the 64-word memory; updates the model on stores
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] exp_rdata, output logic exp_err);
    exp_err   = is_misaligned(addr);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) model[word_of(addr, 64)] = wdata;
      else    exp_rdata = model[word_of(addr, 64)];
    end
  endtask

  // Drives one transaction; reports what was observed, leaves comparisons to callers
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input bit poke,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output bit ready_low, output bit stable, output bit after_ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; ready_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready !== 1'b0) ready_low = 1'b0;
    end while (resp_valid !== 1'b1 && lat < 40);
    rdata = resp_rdata; err = resp_err; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid = poke; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err || req_ready !== 1'b0)
        stable = 1'b0;
    end
    req_valid = poke;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    after_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0; r0_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else n_pass++;
    n_total++; if (resp_rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", resp_rdata); else n_pass++;
    n_total++; if (resp_err !== 1'b0) $display("FAIL reset_err got %b exp 0", resp_err); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    int bad_lat, bad_data;
    bad_lat = 0; bad_data = 0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] d;
      d = $urandom;
      model_txn(1'b1, 32'(i * 4), d, erd, eer);
      run_txn(1'b1, 32'(i * 4), d, 0, 1'b0, rd, er, lat, rl, st, ao);
      if (lat != 3 || !rl || !ao) bad_lat++;
      if (rd !== erd || er !== eer) bad_data++;
    end
    n_total++; if (bad_lat != 0) $display("FAIL fill_timing got %0d bad txns exp 0", bad_lat); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL fill_store_resp got %0d bad txns exp 0", bad_data); else n_pass++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    model_txn(1'b1, 32'h10, 32'hDEADBEEF, erd, eer);
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (lat != 3) $display("FAIL store_latency got %0d exp 3", lat); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL store_rdata got %h exp 0", rd); else n_pass++;
    model_txn(1'b0, 32'h10, 32'd0, erd, eer);
    run_txn(1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (lat != 3) $display("FAIL load_latency got %0d exp 3", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_raw got %h exp deadbeef", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL load_err got %b exp 0", er); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    model_txn(1'b1, 32'h4, 32'hA5A5A5A5, erd, eer);
    run_txn(1'b1, 32'h4, 32'hA5A5A5A5, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (rl !== 1'b1) $display("FAIL wrap_store_ready_low got %b exp 1", rl); else n_pass++;
    model_txn(1'b0, 32'h104, 32'd0, erd, eer);
    run_txn(1'b0, 32'h104, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (rd !== 32'hA5A5A5A5) $display("FAIL wrap_load got %h exp a5a5a5a5", rd); else n_pass++;
    n_total++; if (rl !== 1'b1) $display("FAIL wrap_load_ready_low got %b exp 1", rl); else n_pass++;
  endtask

  task automatic test_hold();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    logic [31:0] a;
    a = {$urandom_range(0, 63), 2'b00};
    model_txn(1'b0, a, 32'd0, erd, eer);
    run_txn(1'b0, a, 32'd0, 5, 1'b1, rd, er, lat, rl, st, ao);
    n_total++; if (rd !== erd) $display("FAIL hold_rdata got %h exp %h", rd, erd); else n_pass++;
    n_total++; if (st !== 1'b1) $display("FAIL hold_stable got %b exp 1", st); else n_pass++;
    n_total++; if (ao !== 1'b1) $display("FAIL hold_complete_idle got %b exp 1", ao); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      logic we; logic [31:0] a, d; int h;
      we = 1'($urandom); a = $urandom; d = $urandom; h = $urandom_range(0, 2);
      model_txn(we, a, d, erd, eer);
      run_txn(we, a, d, h, 1'($urandom), rd, er, lat, rl, st, ao);
      if (rd !== erd || er !== eer || lat != 3 || !rl || !st || !ao) begin
        bad++;
        $display("FAIL random_txn i=%0d we=%b addr=%h got rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=3",
                 i, we, a, rd, er, lat, erd, eer);
      end
    end
    n_total++; if (bad != 0) $display("FAIL random_summary got %0d bad exp 0", bad); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    bit zero_during;
    model[word_of(32'h20, 64)] = 32'hC0FFEE01;
    run_txn(1'b1, 32'h20, 32'hC0FFEE01, 0, 1'b0, rd, er, lat, rl, st, ao);
    run_txn(1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    zero_during = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || req_ready !== 1'b1)
        zero_during = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (zero_during !== 1'b1) $display("FAIL abort_outputs_during_reset got %b exp 1", zero_during); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL abort_ready_after got %b exp 1", req_ready); else n_pass++;
    n_total++; if (resp_rdata !== 32'd0) $display("FAIL abort_rdata_after got %h exp 0", resp_rdata); else n_pass++;
    model_txn(1'b0, 32'h20, 32'd0, erd, eer);
    run_txn(1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (rd !== 32'hC0FFEE01) $display("FAIL abort_store_discarded got %h exp c0ffee01", rd); else n_pass++;
  endtask

  task automatic test_zero_wait();
    int bad_lat, bad_data;
    bad_lat = 0; bad_data = 0;
    for (int i = 0; i < 48; i++) begin
      logic we; logic [31:0] a, d, exp; int lat;
      we = (i < 16) ? 1'b1 : 1'($urandom);
      a  = (i < 16) ? 32'(i * 4) : $urandom;
      d  = $urandom;
      exp = 32'd0;
      if (!is_misaligned(a)) begin
        if (we) model0[word_of(a, 16)] = d;
        else    exp = model0[word_of(a, 16)];
      end
      @(negedge clk);
      r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; r0_resp_ready = 1'b0;
      @(posedge clk); #1;
      r0_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (r0_resp_valid !== 1'b1 && lat < 20);
      if (lat != 1) bad_lat++;
      if (r0_rdata !== exp || r0_resp_err !== is_misaligned(a)) begin
        bad_data++;
        $display("FAIL zero_wait_txn i=%0d addr=%h got %h exp %h", i, a, r0_rdata, exp);
      end
      r0_resp_ready = 1'b1;
      @(posedge clk); #1;
      r0_resp_ready = 1'b0;
    end
    n_total++; if (bad_lat != 0) $display("FAIL zero_wait_latency got %0d bad exp 0", bad_lat); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL zero_wait_data got %0d bad exp 0", bad_data); else n_pass++;
  endtask

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  task automatic test_align();
    logic [31:0] rd, erd; logic er, eer; int lat; bit rl, st, ao;
    model_txn(1'b1, 32'h22, 32'h12345678, erd, eer);
    run_txn(1'b1, 32'h22, 32'h12345678, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (er !== 1'b1) $display("FAIL align_store_err got %b exp 1", er); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL align_store_rdata got %h exp 0", rd); else n_pass++;
    n_total++; if (lat != 3) $display("FAIL align_latency got %0d exp 3", lat); else n_pass++;
    model_txn(1'b0, 32'h20, 32'd0, erd, eer);
    run_txn(1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (rd !== erd) $display("FAIL align_unchanged got %h exp %h", rd, erd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL align_aligned_err got %b exp 0", er); else n_pass++;
    model_txn(1'b0, 32'h21, 32'd0, erd, eer);
    run_txn(1'b0, 32'h21, 32'd0, 0, 1'b0, rd, er, lat, rl, st, ao);
    n_total++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL align_load_fault got err=%b rdata=%h exp err=1 rdata=0", er, rd); else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_fill();
    test_store_load();
    test_wrap();
    test_hold();
    test_random();
    test_reset_abort();
    test_zero_wait();
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    test_align();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
